// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer.
//   shift_op_t  : shift operation held for the duration of a request
//   seq_state_t : sequencer FSM states
//   decode_op   : maps the raw 2-bit request op onto shift_op_t (2'b11 -> SLL)
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

    // The unused encoding 2'b11 behaves as a logical left shift.
    function automatic shift_op_t decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   return SHIFT_SRL;
            2'b10:   return SHIFT_SRA;
            default: return SHIFT_SLL;
        endcase
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts an N-bit value by 0..STEP bits.
// Ports:
//   op     : shift operation (SLL / SRL / SRA)
//   fill   : bit shifted in from the MSB side for SRA (original operand MSB)
//   data   : value to shift
//   amt    : shift distance, 0..STEP
//   result : shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 8,
    localparam int AW  = $clog2(STEP) + 1
) (
    input  shift_op_t       op,
    input  logic            fill,
    input  logic [N-1:0]    data,
    input  logic [AW-1:0]   amt,
    output logic [N-1:0]    result
);

    // Prepending the fill bit lets a signed shift replicate it into the
    // vacated MSBs; the extra top bit is discarded by the cast.
    logic signed [N:0] ext;
    assign ext = {fill, data};

    always_comb begin
        result = data << amt;
        case (op)
            SHIFT_SRL: result = data >> amt;
            SHIFT_SRA: result = N'(ext >>> amt);
            default:   result = data << amt;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: applies at most STEP bits of shift per cycle
// using one shared shift_step, then holds the result until it is consumed.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   in_op, in_data      : operation and operand, sampled at accept
//   in_shamt            : shift amount, only the low $clog2(N) bits used
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_data            : working register (meaningful when out_valid)
//   busy                : high whenever the sequencer is not IDLE
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [N-1:0]  in_data,
    input  logic [N-1:0]  in_shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy
);

    localparam int SW = $clog2(N);
    localparam int AW = $clog2(STEP) + 1;

    seq_state_t    state_q, state_d;
    shift_op_t     op_q, op_d;
    logic          fill_q, fill_d;
    logic [N-1:0]  work_q, work_d;
    logic [SW-1:0] rem_q, rem_d;

    logic          last_step;
    logic [AW-1:0] step_amt;
    logic [N-1:0]  step_out;
    logic [SW-1:0] shamt;

    // Upper shift-amount bits are intentionally ignored.
    logic unused_shamt_bits;
    assign unused_shamt_bits = ^in_shamt;
    assign shamt = in_shamt[SW-1:0];

    // k = min(remaining, STEP); the step that consumes the remainder is last.
    assign last_step = ({1'b0, rem_q} <= (SW+1)'(STEP));
    assign step_amt  = last_step ? AW'(rem_q) : AW'(STEP);

    shift_step #(
        .N    (N),
        .STEP (STEP)
    ) u_step (
        .op     (op_q),
        .fill   (fill_q),
        .data   (work_q),
        .amt    (step_amt),
        .result (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= SHIFT_SLL;
            fill_q  <= 1'b0;
            work_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fill_d  = fill_q;
        work_d  = work_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = decode_op(in_op);
                    fill_d = in_data[N-1];
                    work_d = in_data;
                    rem_d  = shamt;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - SW'(step_amt);
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (N=32, STEP=8). Expected results
// and latencies come from a bit-serial reference model, are queued when a
// request is driven and are popped when the DUT raises out_valid.
module tb_shift_sequencer;

    localparam int N    = 32;
    localparam int STEP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [N-1:0]  in_data;
    logic [N-1:0]  in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;

    typedef struct {
        logic [31:0] data;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .N    (N),
        .STEP (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Counts every comparison and reports any mismatch on one line.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: shifts one bit at a time.
    function automatic logic [31:0] modelShift(input logic [1:0] op, input logic [31:0] d, input logic [31:0] sh);
        logic [31:0] r;
        int s;
        r = d;
        s = int'(sh[4:0]);
        for (int i = 0; i < s; i++) begin
            case (op)
                2'b01:   r = {1'b0, r[31:1]};
                2'b10:   r = {d[31], r[31:1]};
                default: r = {r[30:0], 1'b0};
            endcase
        end
        return r;
    endfunction

    // Drives one request, scrambles the inputs while the DUT works, then
    // waits (bounded) for out_valid and checks latency and data.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] d, input logic [31:0] sh, input string tag);
        exp_t e;
        int   s;
        int   cnt;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        s = int'(sh[4:0]);
        e.data = modelShift(op, d, sh);
        e.lat  = 1 + (s + STEP - 1) / STEP;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk); #1;
        in_op    = 2'($urandom);
        in_data  = $urandom;
        in_shamt = $urandom;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        checkOutput({e.tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({e.tag, "_latency"}, cnt, e.lat);
        checkOutput({e.tag, "_data"}, out_data, e.data);
    endtask

    // Lets the DONE edge pass with out_ready high and checks return to IDLE.
    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, "_idle"}, {29'b0, busy, in_ready, out_valid}, 32'b010);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] held;
        logic        seen_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b1;

        #12;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        applyStimulus(2'b00, 32'h6cb0b7d9, 32'd0, "sll_s0");
        releaseResult("sll_s0");
        applyStimulus(2'b00, 32'h6cb0b7d9, 32'd4, "sll_s4");
        releaseResult("sll_s4");
        applyStimulus(2'b10, 32'h80000000, 32'd31, "sra_s31");
        releaseResult("sra_s31");
        applyStimulus(2'b01, 32'h80000000, 32'd31, "srl_s31");
        releaseResult("srl_s31");
        applyStimulus(2'b00, 32'h00000001, 32'h00000025, "sll_upper");
        releaseResult("sll_upper");
        applyStimulus(2'b11, 32'h0000f00f, 32'd8, "op11_s8");
        releaseResult("op11_s8");
        applyStimulus(2'b10, 32'h7f00ff00, 32'd9, "sra_pos_s9");
        releaseResult("sra_pos_s9");
        applyStimulus(2'b01, 32'hdeadbeef, 32'd16, "srl_s16");
        releaseResult("srl_s16");

        // Back-pressure: result must hold while out_ready is low
        out_ready = 1'b0;
        applyStimulus(2'b01, 32'hcafef00d, 32'd9, "stall");
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_data", out_data, held);
            checkOutput("stall_flags", {29'b0, busy, in_ready, out_valid}, 32'b101);
        end
        releaseResult("stall");

        // Reset in the middle of a long shift aborts it
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_data  = 32'h80000000;
        in_shamt = 32'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_busy_before", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_out_data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        checkOutput("abort_no_valid", {31'b0, seen_valid}, 32'd0);
        applyStimulus(2'b10, 32'h80000000, 32'd31, "after_abort");
        releaseResult("after_abort");

        // Random vectors
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, "rand");
            releaseResult("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
